// File: rtl/pa8255_pkg.sv
// Shared definitions for the 8255-style port-A write controller:
// bus address decodes, control-word layout, mode encodings and the
// registered bus snapshot used by the input pipeline.
package pa8255_pkg;

   // Register addresses on the CPU bus
   localparam logic [1:0] PORT_A = 2'b00;
   localparam logic [1:0] CTRL   = 2'b11;

   // Control word loaded while reset is asserted (port A input, mode 0)
   localparam logic [7:0] CTRL_RST_DEFAULT = 8'h9B;

   // Control-word field positions
   localparam int CW_MODE_SET_BIT = 7;
   localparam int CW_PA_DIR_BIT   = 4;

   // Bit number addressed by a bit set/reset command to reach INTE_A
   localparam logic [2:0] INTE_A_BIT = 3'd6;

   // Group-A mode field ctrl_word[6:5]; only MODE_1 has a handshake
   typedef enum logic [1:0] {
      MODE_0  = 2'b00,
      MODE_1  = 2'b01,
      MODE_2  = 2'b10,
      MODE_2X = 2'b11
   } mode_e;

   // One registered snapshot of the CPU bus inputs
   typedef struct packed {
      logic       cs_n;
      logic       wr_n;
      logic [1:0] a;
      logic [7:0] d;
   } bus_s;

   // Idle bus: no chip select, no write strobe
   localparam bus_s BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, a: 2'b00, d: 8'h00};

   // Extract the group-A mode from a control word
   function automatic mode_e decode_mode(input logic [7:0] cw);
      return mode_e'(cw[6:5]);
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a level that idles high; both flops reset to 1
// so a reset never manufactures an edge on the synchronised output.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   // Two back-to-back flops; the first may go metastable, the second settles it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         q      <= 1'b1;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/pa_write_ctrl.sv
// Port-A write controller: registers the CPU bus twice, detects write
// start/commit from the registered wr_n edges, maintains the control word,
// drives the port-A output latch strobe/data and runs the mode-1 output
// handshake (OBF/ACK/INTR) from a synchronised ack_a_n.
module pa_write_ctrl
   import pa8255_pkg::*;
#(
   parameter logic [7:0] CTRL_RST = CTRL_RST_DEFAULT
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic [1:0] a,
   input  logic [7:0] d,
   input  logic       ack_a_n,
   output logic       pa_out_ld_n,
   output logic [7:0] pa_out_data,
   output logic       obf_a_n,
   output logic       intr_a,
   output logic [7:0] ctrl_word
);

   bus_s       s1_q, s1_d;
   bus_s       s2_q, s2_d;
   logic       ack_sync;
   logic       ack_prev_q, ack_prev_d;
   logic [7:0] ctrl_q, ctrl_d;
   logic [7:0] data_q, data_d;
   logic       ld_n_q, ld_n_d;
   logic       obf_n_q, obf_n_d;
   logic       intr_q, intr_d;
   logic       inte_q, inte_d;

   logic       wr_commit;
   logic       wr_start;
   logic       ack_fall;
   logic       ack_rise;
   logic       mode1;
   logic       pa_is_input;

   sync2 u_ack_sync (
      .clk   (clk),
      .rst_n (reset_n),
      .d     (ack_a_n),
      .q     (ack_sync)
   );

   // Bus pipeline inputs and ack edge-detect history
   always_comb begin
      s1_d.cs_n  = cs_n;
      s1_d.wr_n  = wr_n;
      s1_d.a     = a;
      s1_d.d     = d;
      s2_d       = s1_q;
      ack_prev_d = ack_sync;
   end

   // Bus pipeline and ack edge register; idle values under reset so a write
   // in flight when reset hits can never complete afterwards
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_q       <= BUS_IDLE;
         s2_q       <= BUS_IDLE;
         ack_prev_q <= 1'b1;
      end else begin
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         ack_prev_q <= ack_prev_d;
      end
   end

   // Event decode from the registered bus and synchronised ack
   always_comb begin
      wr_commit   = !s2_q.wr_n && s1_q.wr_n && !s2_q.cs_n;
      wr_start    = s2_q.wr_n && !s1_q.wr_n && !s1_q.cs_n && (s1_q.a == PORT_A);
      ack_fall    = !ack_sync && ack_prev_q;
      ack_rise    = ack_sync && !ack_prev_q;
      mode1       = (decode_mode(ctrl_q) == MODE_1);
      pa_is_input = ctrl_q[CW_PA_DIR_BIT];
   end

   // Next-state for the control/output registers; later assignments take
   // priority, which gives commit over ack-fall and write-start over intr-set
   always_comb begin
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      ld_n_d  = 1'b1;
      obf_n_d = obf_n_q;
      intr_d  = intr_q;
      inte_d  = inte_q;

      // Mode-1 handshake events from the peripheral
      if (mode1) begin
         if (ack_fall) begin
            obf_n_d = 1'b1;
         end
         if (ack_rise && obf_n_q && inte_q) begin
            intr_d = 1'b1;
         end
      end

      // CPU write commits
      if (wr_commit) begin
         case (s2_q.a)
            PORT_A: begin
               if (!pa_is_input) begin
                  data_d = s2_q.d;
                  ld_n_d = 1'b0;
                  if (mode1) begin
                     obf_n_d = 1'b0;
                  end
               end
            end
            CTRL: begin
               if (s2_q.d[CW_MODE_SET_BIT]) begin
                  ctrl_d  = s2_q.d;
                  data_d  = 8'h00;
                  ld_n_d  = 1'b0;
                  obf_n_d = 1'b1;
                  intr_d  = 1'b0;
                  inte_d  = 1'b0;
               end else if (s2_q.d[3:1] == INTE_A_BIT) begin
                  inte_d = s2_q.d[0];
               end
            end
            default: begin
            end
         endcase
      end

      // Starting a port-A write acknowledges the pending interrupt
      if (wr_start) begin
         intr_d = 1'b0;
      end

      // Without the mode-1 handshake the status outputs sit at idle
      if (!mode1) begin
         obf_n_d = 1'b1;
         intr_d  = 1'b0;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q  <= CTRL_RST;
         data_q  <= 8'h00;
         ld_n_q  <= 1'b1;
         obf_n_q <= 1'b1;
         intr_q  <= 1'b0;
         inte_q  <= 1'b0;
      end else begin
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         ld_n_q  <= ld_n_d;
         obf_n_q <= obf_n_d;
         intr_q  <= intr_d;
         inte_q  <= inte_d;
      end
   end

   assign pa_out_ld_n = ld_n_q;
   assign pa_out_data = data_q;
   assign obf_a_n     = obf_n_q;
   assign intr_a      = intr_q;
   assign ctrl_word   = ctrl_q;

endmodule

// File: tb/tb_pa_write_ctrl.sv
// Bench for pa_write_ctrl: directed scenarios followed by random CPU writes
// and ack pulses, compared against a transaction-level model of the port.
module tb_pa_write_ctrl;

   logic       clk;
   logic       reset_n;
   logic       cs_n;
   logic       wr_n;
   logic [1:0] a;
   logic [7:0] d;
   logic       ack_a_n;
   logic       pa_out_ld_n;
   logic [7:0] pa_out_data;
   logic       obf_a_n;
   logic       intr_a;
   logic [7:0] ctrl_word;

   int checks   = 0;
   int failures = 0;

   // Strobe monitor state
   int pulse_cnt  = 0;
   int consec_cnt = 0;
   bit prev_low   = 1'b0;

   // Transaction-level model of the port
   logic [7:0] m_ctrl;
   logic [7:0] m_data;
   logic       m_obf;
   logic       m_intr;
   logic       m_inte;
   int         m_pulses;

   pa_write_ctrl #(.CTRL_RST(8'h9B)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cs_n        (cs_n),
      .wr_n        (wr_n),
      .a           (a),
      .d           (d),
      .ack_a_n     (ack_a_n),
      .pa_out_ld_n (pa_out_ld_n),
      .pa_out_data (pa_out_data),
      .obf_a_n     (obf_a_n),
      .intr_a      (intr_a),
      .ctrl_word   (ctrl_word)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count load strobes and flag any strobe lasting two cycles
   always @(negedge clk) begin
      if (pa_out_ld_n === 1'b0) begin
         pulse_cnt <= pulse_cnt + 1;
         if (prev_low) consec_cnt <= consec_cnt + 1;
      end
      prev_low <= (pa_out_ld_n === 1'b0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_mode1();
      return (m_ctrl[6:5] == 2'b01);
   endfunction

   function automatic void model_reset();
      m_ctrl = 8'h9B;
      m_data = 8'h00;
      m_obf  = 1'b1;
      m_intr = 1'b0;
      m_inte = 1'b0;
   endfunction

   function automatic void model_write(input logic [1:0] wa, input logic [7:0] wd);
      m_pulses = 0;
      if (wa == 2'b00) begin
         m_intr = 1'b0;
         if (!m_ctrl[4]) begin
            m_data   = wd;
            m_pulses = 1;
            if (m_mode1()) m_obf = 1'b0;
         end
      end else if (wa == 2'b11) begin
         if (wd[7]) begin
            m_ctrl   = wd;
            m_data   = 8'h00;
            m_pulses = 1;
            m_obf    = 1'b1;
            m_intr   = 1'b0;
            m_inte   = 1'b0;
         end else if (wd[3:1] == 3'd6) begin
            m_inte = wd[0];
         end
      end
   endfunction

   function automatic void model_ack_fall();
      if (m_mode1()) m_obf = 1'b1;
   endfunction

   function automatic void model_ack_rise();
      if (m_mode1() && m_obf && m_inte) m_intr = 1'b1;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_ctrl"}, ctrl_word, m_ctrl);
      check({tag, "_data"}, pa_out_data, m_data);
      check({tag, "_ld_n"}, pa_out_ld_n, 1'b1);
      check({tag, "_obf"}, obf_a_n, m_obf);
      check({tag, "_intr"}, intr_a, m_intr);
   endtask

   // One CPU write, wr_n low for len cycles; optionally drops ack_a_n so its
   // synchronised falling edge lands on the commit edge
   task automatic do_write(input string tag, input logic [1:0] wa, input logic [7:0] wd,
                           input int len, input bit aligned);
      int base;
      base = pulse_cnt;
      @(negedge clk);
      cs_n = 1'b0;
      wr_n = 1'b0;
      a    = wa;
      d    = wd;
      repeat (len - 1) @(negedge clk);
      if (aligned) ack_a_n = 1'b0;
      @(negedge clk);
      wr_n = 1'b1;
      cs_n = 1'b1;
      if (aligned) model_ack_fall();
      model_write(wa, wd);
      repeat (5) @(negedge clk);
      check({tag, "_pulses"}, pulse_cnt - base, m_pulses);
   endtask

   task automatic ack_pulse();
      @(negedge clk);
      ack_a_n = 1'b0;
      model_ack_fall();
      repeat (5) @(negedge clk);
      ack_a_n = 1'b1;
      model_ack_rise();
      repeat (5) @(negedge clk);
   endtask

   initial begin
      int base;
      reset_n = 1'b0;
      cs_n    = 1'b1;
      wr_n    = 1'b1;
      a       = 2'b00;
      d       = 8'h00;
      ack_a_n = 1'b1;
      model_reset();
      m_pulses = 0;

      // Reset state
      repeat (3) @(negedge clk);
      check_outputs("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Default control word: port A is an input, no strobe
      do_write("pa_input", 2'b00, 8'hFF, 2, 1'b0);
      check_outputs("pa_input");

      // Mode set then port-A output write
      do_write("modeset80", 2'b11, 8'h80, 1, 1'b0);
      check_outputs("modeset80");
      do_write("wr5a", 2'b00, 8'h5A, 3, 1'b0);
      check_outputs("wr5a");

      // Mode-1 handshake
      do_write("modeA0", 2'b11, 8'hA0, 2, 1'b0);
      do_write("inte_set", 2'b11, 8'h0D, 1, 1'b0);
      do_write("wr3c", 2'b00, 8'h3C, 2, 1'b0);
      check_outputs("wr3c");
      check("wr3c_obf_low", obf_a_n, 1'b0);
      @(negedge clk);
      ack_a_n = 1'b0;
      @(negedge clk);
      check("ack_lat_e1", obf_a_n, 1'b0);
      @(negedge clk);
      check("ack_lat_e2", obf_a_n, 1'b0);
      @(negedge clk);
      check("ack_lat_e3", obf_a_n, 1'b1);
      model_ack_fall();
      repeat (3) @(negedge clk);
      ack_a_n = 1'b1;
      model_ack_rise();
      repeat (5) @(negedge clk);
      check("intr_after_ack", intr_a, 1'b1);
      check_outputs("after_ack");
      do_write("start_clr", 2'b00, 8'h11, 2, 1'b0);
      check("intr_cleared", intr_a, 1'b0);
      check_outputs("start_clr");

      // Ack fall coinciding with a commit: commit wins
      ack_pulse();
      check_outputs("pre_align");
      do_write("aligned", 2'b00, 8'hC3, 1, 1'b1);
      check("aligned_obf", obf_a_n, 1'b0);
      @(negedge clk);
      ack_a_n = 1'b1;
      model_ack_rise();
      repeat (5) @(negedge clk);
      check("aligned_intr", intr_a, 1'b0);
      check_outputs("aligned");

      // Random writes and ack pulses
      for (int i = 0; i < 60; i++) begin
         int         r;
         logic [7:0] rd;
         int         len;
         r   = $urandom_range(0, 9);
         rd  = 8'($urandom);
         len = $urandom_range(1, 3);
         if (r <= 1) begin
            ack_pulse();
         end else if (r <= 4 || r == 9) begin
            do_write("rnd_pa", 2'b00, rd, len, 1'b0);
         end else if (r <= 6) begin
            rd[7] = 1'b1;
            if ($urandom_range(0, 1) == 1) rd[6:5] = 2'b01;
            if ($urandom_range(0, 1) == 1) rd[4] = 1'b0;
            do_write("rnd_mode", 2'b11, rd, len, 1'b0);
         end else if (r == 7) begin
            rd[7] = 1'b0;
            if ($urandom_range(0, 1) == 1) rd[3:1] = 3'd6;
            do_write("rnd_bsr", 2'b11, rd, len, 1'b0);
         end else begin
            do_write("rnd_ign", 2'($urandom_range(1, 2)), rd, len, 1'b0);
         end
         check_outputs("rnd");
      end

      // Reset asserted one cycle after wr_n rises: pending commit discarded
      do_write("pre_rst", 2'b11, 8'h80, 1, 1'b0);
      base = pulse_cnt;
      @(negedge clk);
      cs_n = 1'b0;
      wr_n = 1'b0;
      a    = 2'b00;
      d    = 8'h77;
      @(negedge clk);
      wr_n = 1'b1;
      cs_n = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_outputs("rst_mid");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_mid_pulses", pulse_cnt - base, 0);
      check_outputs("rst_after");

      check("no_consec_strobe", consec_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pa_write_ctrl.md
PA_WRITE_CTRL -- requirements
Module: pa_write_ctrl

Interface
REQ-001 Parameter CTRL_RST, default 8'h9B, control word loaded at reset (all ports input, mode 0).
REQ-002 clk  in  1  single clock; all flops on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cs_n  in  1  chip select, active low, synchronous to clk.
REQ-005 wr_n  in  1  CPU write strobe, active low, synchronous to clk.
REQ-006 a  in  2  register address: 00 = port A, 11 = control.
REQ-007 d  in  8  CPU write data.
REQ-008 ack_a_n  in  1  peripheral acknowledge, active low, asynchronous.
REQ-009 pa_out_ld_n  out  1  load strobe to the port-A output latch, active low.
REQ-010 pa_out_data  out  8  data presented to the port-A output latch.
REQ-011 obf_a_n  out  1  output-buffer-full, active low (mode 1).
REQ-012 intr_a  out  1  port-A interrupt request, active high.
REQ-013 ctrl_word  out  8  current control register, for read-back.

Function
REQ-014 Bus inputs (cs_n, wr_n, a, d) SHALL pass through a one-stage register s1, then a second stage s2.
REQ-015 A write commit SHALL occur on the edge where s2.wr_n=0, s1.wr_n=1 and s2.cs_n=0; s2.a and s2.d apply.
REQ-016 A write start SHALL occur on the edge where s2.wr_n=1, s1.wr_n=0, s1.cs_n=0 and s1.a=00.
REQ-017 Commit to a=00 with ctrl_word[4]=0 (port A output): pa_out_data<=s2.d and pa_out_ld_n<=0 for exactly one cycle.
REQ-018 Commit to a=00 with ctrl_word[4]=1 (port A input): no strobe; pa_out_data unchanged.
REQ-019 Commit to a=11 with d[7]=1 (mode set): ctrl_word<=d, pa_out_data<=8'h00, one-cycle pa_out_ld_n pulse, obf_a_n<=1, intr_a<=0, inte_a<=0.
REQ-020 Commit to a=11 with d[7]=0 (bit set/reset): when d[3:1]=3'd6, inte_a<=d[0]; other bit numbers SHALL be ignored; ctrl_word unchanged.
REQ-021 Commits to a=01 or a=10 SHALL have no effect.
REQ-022 Mode decode: ctrl_word[6:5]=01 is mode 1; 00, 10 and 11 SHALL behave as mode 0 (no handshake; obf_a_n held 1, intr_a held 0).
REQ-023 Mode 1 with port A output: a REQ-017 commit SHALL drive obf_a_n<=0 on the same edge as pa_out_ld_n<=0.
REQ-024 ack_a_n SHALL be synchronised by a two-flop sync, followed by one edge-detect register.
REQ-025 Mode 1: a synchronised ack_a_n falling edge SHALL set obf_a_n<=1; latency is 3 edges from ack_a_n falling.
REQ-026 Mode 1: a synchronised ack_a_n rising edge with obf_a_n=1 and inte_a=1 SHALL set intr_a<=1.
REQ-027 A REQ-016 write start SHALL clear intr_a<=0.
REQ-028 Simultaneous commit and ack falling edge: the commit wins (obf_a_n=0).
REQ-029 Simultaneous write start and intr set: the clear wins.
REQ-030 pa_out_ld_n SHALL never be low for two consecutive cycles; back-to-back commits are at least 2 cycles apart by construction.

Reset
REQ-031 While reset_n=0: ctrl_word=CTRL_RST, pa_out_ld_n=1, pa_out_data=8'h00, obf_a_n=1, intr_a=0, inte_a=0.
REQ-032 While reset_n=0: s1/s2 and the sync flops SHALL hold idle values (wr_n=1, cs_n=1, ack=1).
REQ-033 Reset asserted mid-write SHALL discard the pending commit; no strobe follows deassertion.

Structure
REQ-034 Shared package pa8255_pkg SHALL hold address constants (PORT_A=2'b00, CTRL=2'b11), CTRL_RST_DEFAULT=8'h9B, the mode encodings, and the INTE_A bit index 6.
REQ-035 One sub-module, sync2 (two-flop synchroniser, async active-low reset, reset value 1), SHALL be used for ack_a_n.
REQ-036 Output ports SHALL be driven directly from flops; no combinational paths from inputs to outputs.

Verification
REQ-037 Reset release, then write 8'h80 to a=11, then 8'h5A to a=00 -> one pa_out_ld_n pulse with 8'h00 after the mode set, then one pulse with pa_out_data=8'h5A; obf_a_n stays 1.
REQ-038 Write 8'hA0 (mode 1 output), 8'h0D (INTE_A=1), then 8'h3C to a=00 -> obf_a_n=0; ack_a_n low then high -> obf_a_n=1 after 3 edges, intr_a=1 after ack rises; next write start clears intr_a.
REQ-039 Default control word (port A input): write 8'hFF to a=00 -> no pa_out_ld_n pulse; pa_out_data stays 8'h00.
REQ-040 Mode 1 with ack_a_n falling aligned to the commit edge -> obf_a_n=0 and intr_a stays 0.
REQ-041 Assert reset_n=0 one cycle after wr_n rises -> no strobe; all outputs at reset values; ctrl_word=8'h9B.
